// File: rtl/bus_reader_pkg.sv
// Shared constants and types for the bus reader FIFO and its sequence checker.
package bus_reader_pkg;

    localparam int unsigned BUS_W      = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic {
        CHK_IDLE,
        CHK_TRACK
    } chk_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// First-word-fall-through FIFO storage: pointers, occupancy, and a registered head output.
module sync_fifo_mem #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       vld,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_n;
    logic [PW-1:0]    rd_ptr_n;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] rdata_n;

    // Next head: forward the incoming word when it becomes the head on this edge.
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        rdata_n  = '0;
        if (push) wr_ptr_n = wr_ptr + PW'(1);
        if (pop)  rd_ptr_n = rd_ptr + PW'(1);
        cnt_n = cnt + CW'(push) - CW'(pop);
        if (cnt_n == '0)
            rdata_n = '0;
        else if (push && (rd_ptr_n == wr_ptr))
            rdata_n = wdata;
        else
            rdata_n = mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= 1'b0;
            full   <= 1'b0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            cnt    <= cnt_n;
            vld    <= (cnt_n != '0);
            full   <= (cnt_n == CW'(DEPTH));
            rdata  <= rdata_n;
        end
    end

endmodule

// File: rtl/bus_reader_fifo.sv
// Receive side of the shared counter bus: buffers OE-qualified samples in a FIFO.
// Define BUS_SEQ_CHECK_EN to build the +1 sequence checker driving SEQ_ERR.
module bus_reader_fifo
    import bus_reader_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       OE,
    input  logic                       LD,
    input  logic [WIDTH-1:0]           Y,
    output logic [WIDTH-1:0]           Q,
    output logic                       VLD,
    input  logic                       RDY,
    output logic [$clog2(DEPTH+1)-1:0] CNT,
    output logic                       FULL,
    output logic                       OVF,
    output logic                       SEQ_ERR
);

    logic push;
    logic pop;

    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign pop  = VLD & RDY;
    assign push = OE & (~FULL | pop);

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (Y),
        .rdata (Q),
        .vld   (VLD),
        .cnt   (CNT),
        .full  (FULL)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            OVF <= 1'b0;
        else if (OE && FULL && !pop)
            OVF <= 1'b1;
    end

`ifdef BUS_SEQ_CHECK_EN
    chk_state_t       chk_state;
    logic [WIDTH-1:0] last;

    // Checks every driven sample, including ones dropped on overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_state <= CHK_IDLE;
            last      <= '0;
            SEQ_ERR   <= 1'b0;
        end else begin
            case (chk_state)
                CHK_IDLE: begin
                    if (OE) begin
                        last      <= Y;
                        chk_state <= CHK_TRACK;
                    end
                end
                CHK_TRACK: begin
                    if (!OE) begin
                        chk_state <= CHK_IDLE;
                    end else begin
                        if (!LD && (Y != WIDTH'(last + WIDTH'(1))))
                            SEQ_ERR <= 1'b1;
                        last <= Y;
                    end
                end
                default: chk_state <= CHK_IDLE;
            endcase
        end
    end
`else
    logic unused_ld;
    assign unused_ld = LD;
    assign SEQ_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_reader_fifo.sv
// Directed plus randomized bench for bus_reader_fifo against a queue-based reference model.
module tb_bus_reader_fifo;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = $clog2(D+1);
`ifdef BUS_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          OE;
    logic          LD;
    logic [W-1:0]  Y;
    logic [W-1:0]  Q;
    logic          VLD;
    logic          RDY;
    logic [CW-1:0] CNT;
    logic          FULL;
    logic          OVF;
    logic          SEQ_ERR;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [$];
    bit           m_ovf;
    bit           m_seq;
    bit           m_track;
    logic [W-1:0] m_last;

    bus_reader_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .OE      (OE),
        .LD      (LD),
        .Y       (Y),
        .Q       (Q),
        .VLD     (VLD),
        .RDY     (RDY),
        .CNT     (CNT),
        .FULL    (FULL),
        .OVF     (OVF),
        .SEQ_ERR (SEQ_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model after the edge has settled.
    task automatic check_all(input string tag);
        chk({tag, ".cnt"},  32'(CNT),     32'(mq.size()));
        chk({tag, ".vld"},  32'(VLD),     32'(mq.size() != 0));
        chk({tag, ".q"},    32'(Q),       (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk({tag, ".full"}, 32'(FULL),    32'(mq.size() == D));
        chk({tag, ".ovf"},  32'(OVF),     32'(m_ovf));
        chk({tag, ".seq"},  32'(SEQ_ERR), 32'(SEQ_EN & m_seq));
    endtask

    task automatic step(input string tag, input bit oe_i, input bit ld_i,
                        input logic [W-1:0] y_i, input bit rdy_i, input bit rst_i);
        bit p;
        bit was_full;
        rst_n = rst_i;
        OE    = oe_i;
        LD    = ld_i;
        Y     = oe_i ? y_i : 'x;
        RDY   = rdy_i;
        @(posedge clk);
        if (!rst_i) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_seq   = 1'b0;
            m_track = 1'b0;
        end else begin
            p        = (mq.size() != 0) && rdy_i;
            was_full = (mq.size() == D);
            if (oe_i) begin
                if (m_track && !ld_i && (y_i != W'(m_last + 1))) m_seq = 1'b1;
                m_last  = y_i;
                m_track = 1'b1;
            end else begin
                m_track = 1'b0;
            end
            if (p) void'(mq.pop_front());
            if (oe_i) begin
                if (!was_full || p) mq.push_back(y_i);
                else                m_ovf = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] ry;
        rst_n = 1'b0; OE = 1'b0; LD = 1'b0; Y = '0; RDY = 1'b0;
        m_last = '0; m_ovf = 1'b0; m_seq = 1'b0; m_track = 1'b0;

        step("reset", 0, 0, 0, 0, 0);
        chk("reset.q0", 32'(Q), 32'd0);

        // Load then count, consumer always ready.
        step("t1", 1, 1, 4'h3, 1, 1);
        chk("t1.q3", 32'(Q), 32'h3);
        step("t1", 1, 0, 4'h4, 1, 1);
        step("t1", 1, 0, 4'h5, 1, 1);
        step("t1", 1, 0, 4'h6, 1, 1);
        chk("t1.q6", 32'(Q), 32'h6);
        step("t1", 0, 0, 0, 1, 1);

        // Overflow: ten samples into eight slots, then drain.
        for (int i = 0; i < 10; i++) step("t2", 1, 0, W'(i), 0, 1);
        chk("t2.cnt8", 32'(CNT), 32'd8);
        chk("t2.ovf",  32'(OVF), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2.drain", 32'(Q), 32'(i));
            step("t2", 0, 0, 0, 1, 1);
        end

        // Full with simultaneous push and pop.
        step("t3", 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("t3", 1, 0, W'(i + 1), 0, 1);
        step("t3", 1, 0, 4'h9, 1, 1);
        chk("t3.cnt8", 32'(CNT), 32'd8);
        chk("t3.ovf0", 32'(OVF), 32'd0);
        for (int i = 0; i < 8; i++) step("t3", 0, 0, 0, 1, 1);

        // Checker wrap-around and sticky error.
        step("t4", 0, 0, 0, 0, 0);
        step("t4", 1, 0, 4'hE, 1, 1);
        step("t4", 1, 0, 4'hF, 1, 1);
        step("t4", 1, 0, 4'h0, 1, 1);
        step("t4", 1, 0, 4'h2, 1, 1);
        chk("t4.seq", 32'(SEQ_ERR), 32'(SEQ_EN));
        for (int i = 0; i < 20; i++) step("t4", 1, 0, W'(i + 3), 1, 1);

        // Gap in OE and a parallel load are both legal.
        step("t5", 0, 0, 0, 0, 0);
        step("t5", 1, 0, 4'h5, 1, 1);
        for (int i = 0; i < 3; i++) step("t5", 0, 0, 0, 1, 1);
        step("t5", 1, 0, 4'h9, 1, 1);
        step("t5", 1, 1, 4'hC, 1, 1);
        step("t5", 1, 0, 4'hD, 1, 1);
        chk("t5.seq0", 32'(SEQ_ERR), 32'd0);
        step("t5", 0, 0, 0, 1, 1);

        // Reset wins over a push on the same edge.
        step("t6", 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("t6", 1, 0, W'(i), 0, 1);
        for (int i = 0; i < 3; i++) step("t6", 0, 0, 0, 1, 1);
        chk("t6.cnt5", 32'(CNT), 32'd5);
        step("t6", 1, 0, 4'hA, 0, 0);
        chk("t6.cnt0", 32'(CNT), 32'd0);
        chk("t6.q0",   32'(Q),   32'd0);
        step("t6", 0, 0, 0, 1, 1);

        // Randomized traffic, mostly counting with occasional breaks and resets.
        ry = '0;
        for (int i = 0; i < 400; i++) begin
            bit roe, rld, rrdy, rrst;
            roe  = ($urandom_range(0, 99) < 65);
            rld  = ($urandom_range(0, 99) < 10);
            rrdy = ($urandom_range(0, 99) < 45);
            rrst = ($urandom_range(0, 99) >= 2);
            if (rld || $urandom_range(0, 99) < 8) ry = W'($urandom);
            else                                   ry = W'(ry + 1);
            step("rnd", roe, rld, ry, rrdy, rrst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
